pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush/trap sequencing for a 3-state FSM (RUN/MD_WAIT/TRAP).
// Optional mul/div wait support is compiled in with `define MILANO_MD_EN.
module pipe_ctrl (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ex_lsu_req_i,
  input  logic       ex_lsu_we_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic       id_rs1_used_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs2_used_i,
  input  logic       md_start_i,
  input  logic       md_done_i,
  input  logic       jump_taken_i,
  input  logic       ecall_i,
  input  logic       ebreak_i,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       refresh_if_id_o,
  output logic       refresh_id_ex_o,
  output logic       trap_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_WAIT = 2'b01,
    TRAP    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  localparam logic [1:0] TRAP_CYCLES = 2'd2;

  state_e     r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;

  logic w_trap_req;
  logic w_load_use;
  logic w_md_req;
  logic w_md_done;

  assign w_trap_req = ecall_i | ebreak_i;

  // Only loads produce late data; x0 never carries a real dependency.
  assign w_load_use = ex_lsu_req_i & ~ex_lsu_we_i & (ex_rd_addr_i != 5'd0) &
                      ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                       (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

`ifdef MILANO_MD_EN
  assign w_md_req  = md_start_i & ~md_done_i;
  assign w_md_done = md_done_i;
`else
  logic w_unused_md;
  assign w_unused_md = md_start_i ^ md_done_i;
  assign w_md_req    = 1'b0;
  assign w_md_done   = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = RUN;
    w_cnt_nxt   = 2'd0;
    case (r_state)
      RUN: begin
        if (w_trap_req) begin
          w_state_nxt = TRAP;
          w_cnt_nxt   = TRAP_CYCLES;
        end else if (!jump_taken_i && w_md_req) begin
          w_state_nxt = MD_WAIT;
        end
      end
      MD_WAIT: begin
        if (!w_md_done) w_state_nxt = MD_WAIT;
      end
      TRAP: begin
        // Leave on the edge where the counter reads 1.
        if (r_cnt > 2'd1) begin
          w_state_nxt = TRAP;
          w_cnt_nxt   = r_cnt - 2'd1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_if_o      = 1'b0;
    stall_id_o      = 1'b0;
    refresh_if_id_o = 1'b0;
    refresh_id_ex_o = 1'b0;
    trap_o          = 1'b0;
    if (rst_ni) begin
      case (r_state)
        RUN: begin
          if (w_trap_req) begin
            trap_o          = 1'b1;
            refresh_if_id_o = 1'b1;
            refresh_id_ex_o = 1'b1;
            stall_if_o      = 1'b1;
          end else if (jump_taken_i) begin
            refresh_if_id_o = 1'b1;
            refresh_id_ex_o = 1'b1;
          end else if (w_md_req) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
          end else if (w_load_use) begin
            stall_if_o      = 1'b1;
            refresh_id_ex_o = 1'b1;
          end
        end
        MD_WAIT: begin
          if (!w_md_done) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
          end
        end
        TRAP: begin
          refresh_if_id_o = 1'b1;
          refresh_id_ex_o = 1'b1;
          stall_if_o      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = rst_ni ? r_state : RUN;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level behavioural model predicts each cycle's outputs
// into a queue; a negedge monitor pops and compares. Directed hazard scenarios, then random traffic.
module tb_pipe_ctrl;

`ifdef MILANO_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       ex_lsu_req_i = 1'b0, ex_lsu_we_i = 1'b0;
  logic [4:0] ex_rd_addr_i = '0, id_rs1_addr_i = '0, id_rs2_addr_i = '0;
  logic       id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
  logic       md_start_i = 1'b0, md_done_i = 1'b0;
  logic       jump_taken_i = 1'b0, ecall_i = 1'b0, ebreak_i = 1'b0;
  logic       stall_if_o, stall_id_o, refresh_if_id_o, refresh_id_ex_o, trap_o;
  logic [1:0] state_o;

  pipe_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_lsu_req_i(ex_lsu_req_i), .ex_lsu_we_i(ex_lsu_we_i), .ex_rd_addr_i(ex_rd_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_used_i(id_rs2_used_i),
    .md_start_i(md_start_i), .md_done_i(md_done_i), .jump_taken_i(jump_taken_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
    .refresh_if_id_o(refresh_if_id_o), .refresh_id_ex_o(refresh_id_ex_o),
    .trap_o(trap_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       rst_n, lsu_req, lsu_we;
    logic [4:0] ex_rd, rs1, rs2;
    logic       rs1_used, rs2_used, md_start, md_done, jump, ecall, ebreak;
  } stim_t;

  typedef struct packed {
    logic       stall_if, stall_id, ref_ifid, ref_idex, trap;
    logic [1:0] state;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: remaining trap cycles and an outstanding mul/div flag.
  int trap_left = 0;
  bit md_busy   = 1'b0;

  function automatic exp_t predict(input stim_t s);
    exp_t e = '0;
    bit hazard;
    if (!s.rst_n) begin
      trap_left = 0;
      md_busy   = 1'b0;
      return e;
    end
    e.state = (trap_left > 0) ? 2'b10 : (md_busy ? 2'b01 : 2'b00);
    hazard = s.lsu_req && !s.lsu_we && s.ex_rd != 0 &&
             ((s.rs1_used && s.rs1 == s.ex_rd) || (s.rs2_used && s.rs2 == s.ex_rd));
    if (trap_left > 0) begin
      {e.ref_ifid, e.ref_idex, e.stall_if} = 3'b111;
      trap_left--;
    end else if (md_busy) begin
      if (s.md_done) md_busy = 1'b0;
      else {e.stall_if, e.stall_id} = 2'b11;
    end else if (s.ecall || s.ebreak) begin
      {e.trap, e.ref_ifid, e.ref_idex, e.stall_if} = 4'b1111;
      trap_left = 2;
    end else if (s.jump) begin
      {e.ref_ifid, e.ref_idex} = 2'b11;
    end else if (MD_EN && s.md_start && !s.md_done) begin
      {e.stall_if, e.stall_id} = 2'b11;
      md_busy = 1'b1;
    end else if (hazard) begin
      {e.stall_if, e.ref_idex} = 2'b11;
    end
    return e;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clk_i);
    #1;
    rst_ni        = s.rst_n;
    ex_lsu_req_i  = s.lsu_req;
    ex_lsu_we_i   = s.lsu_we;
    ex_rd_addr_i  = s.ex_rd;
    id_rs1_addr_i = s.rs1;
    id_rs1_used_i = s.rs1_used;
    id_rs2_addr_i = s.rs2;
    id_rs2_used_i = s.rs2_used;
    md_start_i    = s.md_start;
    md_done_i     = s.md_done;
    jump_taken_i  = s.jump;
    ecall_i       = s.ecall;
    ebreak_i      = s.ebreak;
    exp_q.push_back(predict(s));
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_if",      {1'b0, stall_if_o},      {1'b0, e.stall_if});
        check("stall_id",      {1'b0, stall_id_o},      {1'b0, e.stall_id});
        check("refresh_if_id", {1'b0, refresh_if_id_o}, {1'b0, e.ref_ifid});
        check("refresh_id_ex", {1'b0, refresh_id_ex_o}, {1'b0, e.ref_idex});
        check("trap",          {1'b0, trap_o},          {1'b0, e.trap});
        check("state",         state_o,                 e.state);
      end
    end
  end

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  initial begin : stimulus
    stim_t s;
    // Reset, including noisy inputs while held.
    s = idle(); s.rst_n = 1'b0;
    apply(s);
    s.ecall = 1'b1; s.jump = 1'b1; s.md_start = 1'b1;
    apply(s);
    apply(idle());

    // Load-use on rs2, then x0 destination, then a store, then rs1 hit.
    s = idle(); s.lsu_req = 1'b1; s.ex_rd = 5'd5; s.rs2_used = 1'b1; s.rs2 = 5'd5;
    apply(s);
    apply(idle());
    s = idle(); s.lsu_req = 1'b1; s.ex_rd = 5'd0; s.rs1_used = 1'b1; s.rs1 = 5'd0;
    apply(s);
    s = idle(); s.lsu_req = 1'b1; s.lsu_we = 1'b1; s.ex_rd = 5'd7; s.rs1_used = 1'b1; s.rs1 = 5'd7;
    apply(s);
    s = idle(); s.lsu_req = 1'b1; s.ex_rd = 5'd9; s.rs1_used = 1'b1; s.rs1 = 5'd9;
    apply(s);

    // Mul/div: start at cycle 0, done at cycle 4.
    s = idle(); s.md_start = 1'b1;
    apply(s);
    repeat (3) apply(idle());
    s = idle(); s.md_done = 1'b1;
    apply(s);
    apply(idle());
    // Start and done in the same cycle.
    s = idle(); s.md_start = 1'b1; s.md_done = 1'b1;
    apply(s);

    // Trap via ebreak; trap-time events must be ignored.
    s = idle(); s.ebreak = 1'b1;
    apply(s);
    s = idle(); s.ecall = 1'b1; s.jump = 1'b1;
    apply(s);
    s = idle(); s.md_start = 1'b1;
    apply(s);
    apply(idle());

    // Priority: ecall + jump + load-use.
    s = idle(); s.ecall = 1'b1; s.jump = 1'b1; s.lsu_req = 1'b1; s.ex_rd = 5'd3;
    s.rs1_used = 1'b1; s.rs1 = 5'd3;
    apply(s);
    repeat (2) apply(idle());
    // Jump beats load-use.
    s = idle(); s.jump = 1'b1; s.lsu_req = 1'b1; s.ex_rd = 5'd3; s.rs2_used = 1'b1; s.rs2 = 5'd3;
    apply(s);

    // Reset mid mul/div, then a stray done.
    s = idle(); s.md_start = 1'b1;
    apply(s);
    apply(idle());
    s = idle(); s.rst_n = 1'b0;
    apply(s);
    apply(idle());
    s = idle(); s.md_done = 1'b1;
    apply(s);
    // Reset mid trap.
    s = idle(); s.ecall = 1'b1;
    apply(s);
    s = idle(); s.rst_n = 1'b0;
    apply(s);
    apply(idle());

    // md_start held for 10 cycles.
    s = idle(); s.md_start = 1'b1;
    repeat (10) apply(s);
    s = idle(); s.md_done = 1'b1;
    apply(s);
    apply(idle());

    // Random traffic with small register ranges to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      s.rst_n    = ($urandom_range(0, 63) != 0);
      s.lsu_req  = 1'($urandom_range(0, 1));
      s.lsu_we   = ($urandom_range(0, 3) == 0);
      s.ex_rd    = 5'($urandom_range(0, 3));
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.rs1_used = 1'($urandom_range(0, 1));
      s.rs2_used = 1'($urandom_range(0, 1));
      s.md_start = ($urandom_range(0, 7) == 0);
      s.md_done  = ($urandom_range(0, 3) == 0);
      s.jump     = ($urandom_range(0, 7) == 0);
      s.ecall    = ($urandom_range(0, 19) == 0);
      s.ebreak   = ($urandom_range(0, 19) == 0);
      if (s.md_start && s.md_done) s.lsu_req = 1'b0;
      apply(s);
    end

    repeat (3) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
